// File: rtl/sp_if_out_ddr_sched.sv
// rtl/sp_if_out_ddr_sched.sv - round-robin DDR write scheduler for the SP output datapath
//
// Purpose: arbitrates DDR write requests from NCH producers round-robin, issues
// the datapath start pulse with size/address, then supervises the Avalon-ST
// write stream (first/last beats, beat count, stall timeout) and reports
// per-channel completion or error. One transfer at a time.
//
// Ports:
//   i_arst, i_clk156m          async active-high reset, 156.25 MHz clock
//   i_ctrl_startp              synchronous abort/clear, highest priority
//   i_req/i_req_size/i_req_addr per-channel request level, byte size, base address
//   o_grant                    one-hot grant pulse
//   o_ddr_wr_startp            datapath start pulse
//   o_ddr_size/o_ddr_addr      size/address of current transfer
//   o_ch_sel                   current/last granted channel index
//   i_wr_valid/ready/first/last write stream handshake and framing flags
//   o_busy                     transfer in progress
//   o_done                     per-channel completion pulse
//   o_err_size/len/tmo         bad size, beat count mismatch, stall timeout pulses
module sp_if_out_ddr_sched #(
  parameter int          NCH       = 2,
  parameter logic [31:0] TMO_CYC   = 32'd1_000_000,
  parameter logic [11:0] START_GAP = 12'd2056
) (
  input  logic              i_arst,
  input  logic              i_clk156m,
  input  logic              i_ctrl_startp,
  input  logic [NCH-1:0]    i_req,
  input  logic [32*NCH-1:0] i_req_size,
  input  logic [32*NCH-1:0] i_req_addr,
  output logic [NCH-1:0]    o_grant,
  output logic              o_ddr_wr_startp,
  output logic [31:0]       o_ddr_size,
  output logic [31:0]       o_ddr_addr,
  output logic [2:0]        o_ch_sel,
  input  logic              i_wr_valid,
  input  logic              i_wr_ready,
  input  logic              i_wr_first,
  input  logic              i_wr_last,
  output logic              o_busy,
  output logic [NCH-1:0]    o_done,
  output logic              o_err_size,
  output logic              o_err_len,
  output logic              o_err_tmo
);

  typedef enum logic [2:0] {
    S_IDLE, S_ARB, S_START, S_WAIT_FIRST, S_WAIT_LAST, S_CHECK
  } state_t;

  state_t      state;
  logic [2:0]  ptr;
  logic        size_bad;
  logic [31:0] exp_beats;
  logic [31:0] beat_cnt;
  logic [31:0] tmo_cnt;

  logic           beat;
  logic [31:0]    beat_inc;
  logic [31:0]    tmo_inc;
  logic [7:0]     req_ext;
  logic [3:0]     arb_idx;
  logic           arb_hit;
  logic [2:0]     arb_sel;
  logic [NCH-1:0] arb_onehot;
  logic [NCH-1:0] done_onehot;
  logic [31:0]    arb_size;
  logic [31:0]    arb_addr;
  logic           arb_bad;

  assign beat     = i_wr_valid & i_wr_ready;
  assign beat_inc = (beat_cnt == 32'hFFFF_FFFF) ? beat_cnt : beat_cnt + 32'd1;
  assign tmo_inc  = tmo_cnt + 32'd1;

  // Round-robin search from ptr+1 upward; iterating the offset downward lets
  // the smallest offset with a set request win.
  always_comb begin
    req_ext            = '0;
    req_ext[NCH-1:0]   = i_req;
    arb_idx            = '0;
    arb_hit            = 1'b0;
    arb_sel            = '0;
    for (int k = NCH; k >= 1; k--) begin
      arb_idx = {1'b0, ptr} + 4'(k);
      if (arb_idx >= 4'(NCH)) arb_idx = arb_idx - 4'(NCH);
      if (req_ext[arb_idx[2:0]]) begin
        arb_hit = 1'b1;
        arb_sel = arb_idx[2:0];
      end
    end
    arb_size    = '0;
    arb_addr    = '0;
    arb_onehot  = '0;
    done_onehot = '0;
    for (int k = 0; k < NCH; k++) begin
      if (arb_sel == 3'(k)) begin
        arb_onehot[k] = 1'b1;
        arb_size      = i_req_size[32*k +: 32];
        arb_addr      = i_req_addr[32*k +: 32];
      end
      if (o_ch_sel == 3'(k)) done_onehot[k] = 1'b1;
    end
    arb_bad = (arb_size == 32'd0) || (arb_size[3:0] != 4'd0);
  end

  // Arbitration is resolved on the IDLE->ARB edge so grant/size/addr are
  // registered and visible in ARB; done/err_len are resolved on the last beat
  // so they appear in CHECK, one cycle after that beat.
  always_ff @(posedge i_clk156m or posedge i_arst) begin
    if (i_arst) begin
      state           <= S_IDLE;
      ptr             <= '0;
      size_bad        <= 1'b0;
      exp_beats       <= '0;
      beat_cnt        <= '0;
      tmo_cnt         <= '0;
      o_grant         <= '0;
      o_ddr_wr_startp <= 1'b0;
      o_ddr_size      <= '0;
      o_ddr_addr      <= '0;
      o_ch_sel        <= '0;
      o_busy          <= 1'b0;
      o_done          <= '0;
      o_err_size      <= 1'b0;
      o_err_len       <= 1'b0;
      o_err_tmo       <= 1'b0;
    end else begin
      o_grant         <= '0;
      o_ddr_wr_startp <= 1'b0;
      o_done          <= '0;
      o_err_size      <= 1'b0;
      o_err_len       <= 1'b0;
      o_err_tmo       <= 1'b0;
      if (i_ctrl_startp) begin
        state    <= S_IDLE;
        ptr      <= 3'(NCH-1);
        beat_cnt <= '0;
        tmo_cnt  <= '0;
        o_busy   <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            if (arb_hit) begin
              state      <= S_ARB;
              o_busy     <= 1'b1;
              o_grant    <= arb_onehot;
              o_ddr_size <= arb_size;
              o_ddr_addr <= arb_addr;
              o_ch_sel   <= arb_sel;
              ptr        <= arb_sel;
              size_bad   <= arb_bad;
              o_err_size <= arb_bad;
              exp_beats  <= {4'd0, arb_size[31:4]};
            end
          end
          S_ARB: begin
            if (size_bad) begin
              state  <= S_IDLE;
              o_busy <= 1'b0;
            end else begin
              state           <= S_START;
              o_ddr_wr_startp <= 1'b1;
            end
          end
          S_START: begin
            beat_cnt <= '0;
            // The datapath start delay is not counted against the stall limit.
            tmo_cnt  <= 32'd0 - 32'(START_GAP);
            state    <= S_WAIT_FIRST;
          end
          S_WAIT_FIRST: begin
            if (beat) begin
              tmo_cnt <= '0;
              if (i_wr_first) begin
                beat_cnt <= 32'd1;
                if (i_wr_last) begin
                  state <= S_CHECK;
                  if (exp_beats == 32'd1) o_done <= done_onehot;
                  else                    o_err_len <= 1'b1;
                end else begin
                  state <= S_WAIT_LAST;
                end
              end else begin
                beat_cnt <= beat_inc;
              end
            end else if (tmo_inc == TMO_CYC) begin
              o_err_tmo <= 1'b1;
              o_busy    <= 1'b0;
              state     <= S_IDLE;
            end else begin
              tmo_cnt <= tmo_inc;
            end
          end
          S_WAIT_LAST: begin
            if (beat) begin
              tmo_cnt  <= '0;
              beat_cnt <= beat_inc;
              if (i_wr_last) begin
                state <= S_CHECK;
                if (beat_inc == exp_beats) o_done <= done_onehot;
                else                       o_err_len <= 1'b1;
              end
            end else if (tmo_inc == TMO_CYC) begin
              o_err_tmo <= 1'b1;
              o_busy    <= 1'b0;
              state     <= S_IDLE;
            end else begin
              tmo_cnt <= tmo_inc;
            end
          end
          S_CHECK: begin
            state  <= S_IDLE;
            o_busy <= 1'b0;
          end
          default: begin
            state  <= S_IDLE;
            o_busy <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
